// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared processor constants used by the datapath adder.
//   XLEN    : native datapath width; default operand width of the adder
//   FLAG_C  : bit index of the carry flag inside a packed flag vector
//   FLAG_V  : bit index of the signed-overflow flag
//   FLAG_Z  : bit index of the zero flag
//   NFLAGS  : width of the packed flag vector
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int XLEN   = 32;
    localparam int NFLAGS = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    // Signed overflow: both operands share a sign that the result does not.
    function automatic logic signed_ovf(input logic a_msb,
                                        input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage : adder_pkg

// File: rtl/adder_cla4.sv
// -----------------------------------------------------------------------------
// cla4
// 4-bit carry-lookahead slice. Produces its sum bits plus the group
// generate/propagate pair consumed by the group lookahead level in adder.
//   a, b : 4-bit operand slices
//   ci   : carry into the slice
//   s    : 4-bit sum slice
//   g    : group generate (slice produces a carry regardless of ci)
//   p    : group propagate (slice passes ci through to its carry out)
// -----------------------------------------------------------------------------
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       g,
    output logic       p
);

    logic [3:0] gen_s;
    logic [3:0] prop_s;
    logic [3:0] carry_s;

    // Bit-level generate/propagate, internal lookahead carries and slice outputs.
    always_comb begin
        gen_s  = a & b;
        prop_s = a ^ b;

        carry_s[0] = ci;
        carry_s[1] = gen_s[0] | (prop_s[0] & ci);
        carry_s[2] = gen_s[1] | (prop_s[1] & gen_s[0])
                   | (prop_s[1] & prop_s[0] & ci);
        carry_s[3] = gen_s[2] | (prop_s[2] & gen_s[1])
                   | (prop_s[2] & prop_s[1] & gen_s[0])
                   | (prop_s[2] & prop_s[1] & prop_s[0] & ci);

        s = prop_s ^ carry_s;

        g = gen_s[3] | (prop_s[3] & gen_s[2])
          | (prop_s[3] & prop_s[2] & gen_s[1])
          | (prop_s[3] & prop_s[2] & prop_s[1] & gen_s[0]);
        // XOR propagate is safe here: g and p can never both be set per bit.
        p = &prop_s;
    end

endmodule : cla4

// File: rtl/adder.sv
// -----------------------------------------------------------------------------
// adder
// Parameterised two-operand integer adder (PC+4, branch targets). Purely
// combinational sum and flags, plus an optional registered copy.
//   WIDTH   : operand/result width, multiple of 4, >= 4 (default XLEN)
//   clk     : clock for the output register only
//   rst_n   : asynchronous active-low reset of the output register
//   a_in    : operand A (unsigned or two's complement)
//   b_in    : operand B
//   cin     : carry-in
//   en      : capture enable for the output register
//   c_out   : combinational (a_in + b_in + cin) mod 2^WIDTH
//   carry_o : combinational carry out of the MSB
//   ovf_o   : combinational signed overflow
//   zero_o  : combinational, high when c_out == 0
//   sum_q   : registered c_out
//   flags_q : registered {carry_o, ovf_o, zero_o}
//   valid_q : high once sum_q holds a captured result
// -----------------------------------------------------------------------------
module adder
    import adder_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  a_in,
    input  logic [WIDTH-1:0]  b_in,
    input  logic              cin,
    input  logic              en,
    output logic [WIDTH-1:0]  c_out,
    output logic              carry_o,
    output logic              ovf_o,
    output logic              zero_o,
    output logic [WIDTH-1:0]  sum_q,
    output logic [NFLAGS-1:0] flags_q,
    output logic              valid_q
);

    localparam int NG = WIDTH / 4;

    logic [WIDTH-1:0]  sum_s;
    logic [NG-1:0]     grp_g_s;
    logic [NG-1:0]     grp_p_s;
    logic [NG:0]       grp_carry_s;
    logic              run_p_s;
    logic [NFLAGS-1:0] flags_s;

    logic [WIDTH-1:0]  sum_r;
    logic [NFLAGS-1:0] flags_r;
    logic              valid_r;

    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_slice
            cla4 u_cla4 (
                .a  (a_in[4*gi +: 4]),
                .b  (b_in[4*gi +: 4]),
                .ci (grp_carry_s[gi]),
                .s  (sum_s[4*gi +: 4]),
                .g  (grp_g_s[gi]),
                .p  (grp_p_s[gi])
            );
        end
    endgenerate

    // Group lookahead: each slice carry-in is the OR of every lower generate
    // qualified by the propagates above it, plus cin through all propagates.
    always_comb begin
        grp_carry_s    = {(NG+1){1'b0}};
        run_p_s        = 1'b1;
        grp_carry_s[0] = cin;
        for (int i = 0; i < NG; i++) begin
            run_p_s = 1'b1;
            for (int j = i; j >= 0; j--) begin
                grp_carry_s[i+1] = grp_carry_s[i+1] | (run_p_s & grp_g_s[j]);
                run_p_s          = run_p_s & grp_p_s[j];
            end
            grp_carry_s[i+1] = grp_carry_s[i+1] | (run_p_s & cin);
        end
    end

    // Combinational result and flag vector.
    always_comb begin
        flags_s         = {NFLAGS{1'b0}};
        flags_s[FLAG_C] = grp_carry_s[NG];
        flags_s[FLAG_V] = signed_ovf(a_in[WIDTH-1], b_in[WIDTH-1], sum_s[WIDTH-1]);
        flags_s[FLAG_Z] = (sum_s == {WIDTH{1'b0}});
    end

    assign c_out   = sum_s;
    assign carry_o = flags_s[FLAG_C];
    assign ovf_o   = flags_s[FLAG_V];
    assign zero_o  = flags_s[FLAG_Z];

    // Output register: capture the combinational result when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r   <= {WIDTH{1'b0}};
            flags_r <= {NFLAGS{1'b0}};
            valid_r <= 1'b0;
        end else if (en) begin
            sum_r   <= sum_s;
            flags_r <= flags_s;
            valid_r <= 1'b1;
        end else begin
            sum_r   <= sum_r;
            flags_r <= flags_r;
            valid_r <= valid_r;
        end
    end

    assign sum_q   = sum_r;
    assign flags_q = flags_r;
    assign valid_q = valid_r;

endmodule : adder

// File: tb/tb_adder.sv
module tb_adder;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        en;
    logic [31:0] c_out;
    logic        carry_o;
    logic        ovf_o;
    logic        zero_o;
    logic [31:0] sum_q;
    logic [2:0]  flags_q;
    logic        valid_q;

    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        cin8;
    logic        en8;
    logic [7:0]  c8;
    logic        carry8;
    logic        ovf8;
    logic        zero8;
    logic [7:0]  sum8_q;
    logic [2:0]  flags8_q;
    logic        valid8_q;

    int n_tests;
    int n_fail;

    adder #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_in    (a),
        .b_in    (b),
        .cin     (cin),
        .en      (en),
        .c_out   (c_out),
        .carry_o (carry_o),
        .ovf_o   (ovf_o),
        .zero_o  (zero_o),
        .sum_q   (sum_q),
        .flags_q (flags_q),
        .valid_q (valid_q)
    );

    adder #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_in    (a8),
        .b_in    (b8),
        .cin     (cin8),
        .en      (en8),
        .c_out   (c8),
        .carry_o (carry8),
        .ovf_o   (ovf8),
        .zero_o  (zero8),
        .sum_q   (sum8_q),
        .flags_q (flags8_q),
        .valid_q (valid8_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_tests++;
        if (sum_q !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_sum: got %h expected %h", sum_q, 32'h0);
        end
        n_tests++;
        if (flags_q !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected %b", flags_q, 3'b000);
        end
        n_tests++;
        if (valid_q !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b expected %b", valid_q, 1'b0);
        end
        // An enabled edge while reset is held must not capture.
        en = 1'b1;
        a  = 32'd1;
        b  = 32'd2;
        @(posedge clk);
        #1;
        n_tests++;
        if (valid_q !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold_valid: got %b expected %b", valid_q, 1'b0);
        end
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_comb_vectors();
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic [31:0] vs [4];
        logic [2:0]  vf [4];
        va[0] = 32'h03C0_0000; vb[0] = 32'h0000_0004; vs[0] = 32'h03C0_0004; vf[0] = 3'b000;
        va[1] = 32'hFFFF_FFFF; vb[1] = 32'h0000_0001; vs[1] = 32'h0000_0000; vf[1] = 3'b101;
        va[2] = 32'h7FFF_FFFF; vb[2] = 32'h0000_0001; vs[2] = 32'h8000_0000; vf[2] = 3'b010;
        va[3] = 32'h8000_0000; vb[3] = 32'h8000_0000; vs[3] = 32'h0000_0000; vf[3] = 3'b111;
        for (int i = 0; i < 4; i++) begin
            a   = va[i];
            b   = vb[i];
            cin = 1'b0;
            #10;
            n_tests++;
            if (c_out !== vs[i]) begin
                n_fail++;
                $display("FAIL comb_sum[%0d]: got %h expected %h", i, c_out, vs[i]);
            end
            n_tests++;
            if ({carry_o, ovf_o, zero_o} !== vf[i]) begin
                n_fail++;
                $display("FAIL comb_flags[%0d]: got %b expected %b", i,
                         {carry_o, ovf_o, zero_o}, vf[i]);
            end
        end
        // cin alone ripples across every slice boundary.
        a   = 32'hFFFF_FFFF;
        b   = 32'h0000_0000;
        cin = 1'b1;
        #10;
        n_tests++;
        if ({carry_o, c_out} !== 33'h1_0000_0000) begin
            n_fail++;
            $display("FAIL comb_cin_ripple: got %h expected %h", {carry_o, c_out}, 33'h1_0000_0000);
        end
        cin = 1'b0;
    endtask

    task automatic test_register();
        @(negedge clk);
        en = 1'b1;
        a  = 32'd5;
        b  = 32'd7;
        @(posedge clk);
        #1;
        n_tests++;
        if (sum_q !== 32'h0000_000C) begin
            n_fail++;
            $display("FAIL reg_sum: got %h expected %h", sum_q, 32'h0000_000C);
        end
        n_tests++;
        if (valid_q !== 1'b1) begin
            n_fail++;
            $display("FAIL reg_valid: got %b expected %b", valid_q, 1'b1);
        end
        n_tests++;
        if (flags_q !== 3'b000) begin
            n_fail++;
            $display("FAIL reg_flags: got %b expected %b", flags_q, 3'b000);
        end
        @(negedge clk);
        en = 1'b0;
        a  = 32'h1234_0000;
        b  = 32'h0000_5678;
        @(posedge clk);
        #1;
        n_tests++;
        if (sum_q !== 32'h0000_000C) begin
            n_fail++;
            $display("FAIL reg_hold_sum: got %h expected %h", sum_q, 32'h0000_000C);
        end
        n_tests++;
        if (c_out !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL reg_hold_comb: got %h expected %h", c_out, 32'h1234_5678);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        en = 1'b1;
        a  = 32'hFFFF_FFFF;
        b  = 32'h0000_0001;
        @(posedge clk);
        #1;
        n_tests++;
        if ({sum_q, flags_q} !== {32'h0000_0000, 3'b101}) begin
            n_fail++;
            $display("FAIL b2b_first: got %h/%b expected %h/%b", sum_q, flags_q, 32'h0, 3'b101);
        end
        a = 32'h7FFF_FFFF;
        b = 32'h0000_0001;
        @(posedge clk);
        #1;
        n_tests++;
        if ({sum_q, flags_q} !== {32'h8000_0000, 3'b010}) begin
            n_fail++;
            $display("FAIL b2b_second: got %h/%b expected %h/%b", sum_q, flags_q, 32'h8000_0000, 3'b010);
        end
        en = 1'b0;
    endtask

    task automatic test_async_reset();
        // Still in the high phase of clk: no edge until the checks are done.
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (sum_q !== 32'h0) begin
            n_fail++;
            $display("FAIL async_sum: got %h expected %h", sum_q, 32'h0);
        end
        n_tests++;
        if (flags_q !== 3'b000) begin
            n_fail++;
            $display("FAIL async_flags: got %b expected %b", flags_q, 3'b000);
        end
        n_tests++;
        if (valid_q !== 1'b0) begin
            n_fail++;
            $display("FAIL async_valid: got %b expected %b", valid_q, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random32();
        logic [32:0] exp_s;
        logic [32:0] sgn_s;
        for (int i = 0; i < 10000; i++) begin
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom_range(1, 0));
            exp_s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            sgn_s = {a[31], a} + {b[31], b} + {32'd0, cin};
            #1;
            n_tests++;
            if ({carry_o, c_out} !== exp_s ||
                ovf_o !== (sgn_s[32] != sgn_s[31]) ||
                zero_o !== (exp_s[31:0] == 32'd0)) begin
                n_fail++;
                $display("FAIL rand32[%0d]: a=%h b=%h cin=%b got %h v=%b z=%b expected %h",
                         i, a, b, cin, {carry_o, c_out}, ovf_o, zero_o, exp_s);
            end
        end
    endtask

    task automatic test_width8();
        logic [8:0] exp_s;
        logic [8:0] sgn_s;
        for (int i = 0; i < 3000; i++) begin
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            cin8 = 1'($urandom_range(1, 0));
            if (i == 0) begin
                a8 = 8'h7F; b8 = 8'h00; cin8 = 1'b1;
            end else if (i == 1) begin
                a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
            end else begin
                a8 = a8;
            end
            exp_s = {1'b0, a8} + {1'b0, b8} + {8'd0, cin8};
            sgn_s = {a8[7], a8} + {b8[7], b8} + {8'd0, cin8};
            #1;
            n_tests++;
            if ({carry8, c8} !== exp_s ||
                ovf8 !== (sgn_s[8] != sgn_s[7]) ||
                zero8 !== (exp_s[7:0] == 8'd0)) begin
                n_fail++;
                $display("FAIL rand8[%0d]: a=%h b=%h cin=%b got %h v=%b z=%b expected %h",
                         i, a8, b8, cin8, {carry8, c8}, ovf8, zero8, exp_s);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        en      = 1'b0;
        a       = 32'd0;
        b       = 32'd0;
        cin     = 1'b0;
        en8     = 1'b0;
        a8      = 8'd0;
        b8      = 8'd0;
        cin8    = 1'b0;

        test_reset();
        test_comb_vectors();
        test_register();
        test_back_to_back();
        test_async_reset();
        test_random32();
        test_width8();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_adder

// File: doc/adder.md
# adder

Parameterised two-operand integer adder for the pipeline datapath, used for PC+4 and branch-target computation. It produces a purely combinational sum on `c_out`. It also produces carry, signed-overflow and zero flags, plus an optional registered copy of the result for timing-critical consumers. The adder core is a block carry-lookahead structure built from 4-bit lookahead slices.

## Interface
- Reset is asynchronous and active-low, and the block has one clock. Ports are named `clk` and `rst_n` as elsewhere in the codebase.
- `WIDTH`, default 32: operand and result width in bits. It must be a multiple of 4 and at least 4.
- `clk`  in  1: clock; only the output register uses it.
- `rst_n`  in  1: asynchronous active-low reset.
- `a_in`  in  WIDTH: operand A, unsigned or two's complement.
- `b_in`  in  WIDTH: operand B.
- `cin`  in  1: carry-in. Tie it to 0 for a plain add.
- `en`  in  1: capture enable for the output register.
- `c_out`  out  WIDTH: combinational sum, `(a_in + b_in + cin) mod 2^WIDTH`.
- `carry_o`  out  1: combinational carry out of the MSB.
- `ovf_o`  out  1: combinational signed overflow.
- `zero_o`  out  1: combinational flag, high when `c_out == 0`.
- `sum_q`  out  WIDTH: registered `c_out`.
- `flags_q`  out  3: registered flags, ordered {`carry_o`, `ovf_o`, `zero_o`}.
- `valid_q`  out  1: high once `sum_q` holds a captured result.

## Operation
- Sum and carry:
  - `c_out` and `carry_o` are the low WIDTH bits and bit WIDTH of `a_in + b_in + cin`.
  - Results wrap modulo 2^WIDTH, and no saturation is applied.
- Signed overflow: `ovf_o = (a[MSB] == b[MSB]) && (c_out[MSB] != a[MSB])`.
- Zero flag: `zero_o` depends only on `c_out`, regardless of carry.
- Carry-lookahead core:
  - The operands are split into WIDTH/4 slices.
  - Each slice produces its sum bits and its group generate and group propagate signals.
  - A group lookahead level computes the slice carry-ins from `cin`.
  - The result must be bit-identical to a behavioural `+` for all inputs.
- Output register:
  - On a rising `clk` with `en=1`, load `sum_q`, `flags_q` and `valid_q` from the current combinational outputs. `valid_q` is set to 1.
  - With `en=0`, all registered outputs hold their values.
- No internal state influences the combinational path.

## Timing
- Combinational outputs have zero-cycle latency. They are valid within the same delta, independent of `clk` and `rst_n`.
- The registered outputs have 1-cycle latency: the values sampled at edge N appear after edge N.
- Reset values:
  - While `rst_n=0`, `sum_q=0`, `flags_q=0` and `valid_q=0`, asynchronously.
  - Reset asserted mid-operation clears these outputs immediately, without waiting for a clock edge.
- Release is synchronous to the next `clk` edge: the first capture happens on the first rising edge with `rst_n=1` and `en=1`.
- Operand changes between edges affect only the combinational outputs.

## Structure
- Put the `XLEN=32` constant and the flag bit-index constants (`FLAG_C=2`, `FLAG_V=1`, `FLAG_Z=0`) in the shared processor package. `WIDTH` defaults to `XLEN`.
- Use one sub-module, `cla4`:
  - Inputs: 4-bit `a`, 4-bit `b`, `ci`.
  - Outputs: 4-bit `s`, group generate `g` and group propagate `p`.
  - `adder` instantiates it WIDTH/4 times via `generate`.
- The group lookahead logic and the output register live in `adder`.

## Test plan
- a=0x03C0_0000, b=0x0000_0004, cin=0: `c_out=0x03C0_0004`, carry=0, ovf=0, zero=0, all checked 10 ns after applying the operands.
- a=0xFFFF_FFFF, b=0x0000_0001: `c_out=0x0000_0000`, carry=1, ovf=0, zero=1.
- a=0x7FFF_FFFF, b=0x0000_0001: `c_out=0x8000_0000`, ovf=1, carry=0. Also a=0x8000_0000, b=0x8000_0000: `c_out=0`, ovf=1, carry=1, zero=1.
- Register path:
  - With `rst_n=0`, `sum_q=0` and `valid_q=0`.
  - Release reset, drive en=1 with a=5, b=7: after the next edge `sum_q=0x0C` and `valid_q=1`.
  - Set en=0 and change the operands: `sum_q` stays at 0x0C.
- Assert `rst_n=0` between clock edges while `valid_q=1`: `sum_q`, `flags_q` and `valid_q` clear immediately, without waiting for a clock edge.
- Run 10k random operand pairs with random cin: `{carry_o, c_out}` equals the behavioural `a+b+cin` every time, and the same check passes at `WIDTH=8`.
